pos_read_sequencer: RTL

- Read-side controller driving the neighbor-position cache read port and the position preprocessor control inputs.
- Each sweep: fetch home-cell particle count, then walk every reference particle (ref_id) against every broadcast particle (particle_id); done once per phase (0 then 1).
- Honours filter back-pressure by freezing all addresses and asserting pause_reading.
- Signals sweep completion to the PE-level controller.

---
 rtl/pos_read_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/pos_read_sequencer.sv
// Read-side sequencer for the neighbor-position cache: fetches the home-cell count, then
// walks every (ref_id, particle_id) pair once per phase. Optional counters via POS_RD_PERF_CNT_EN.
module pos_read_sequencer #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int COUNT_LATENCY     = 3,
  parameter int PERF_CNT_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         back_pressure,
  input  logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count,
  output logic                         phase,
  output logic                         reading_particle_num,
  output logic                         pause_reading,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
  output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
  output logic                         busy,
  output logic                         sweep_done
`ifdef POS_RD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0]    stall_cycles,
  output logic [PERF_CNT_WIDTH-1:0]    active_cycles
`endif
);

  localparam int W     = PARTICLE_ID_WIDTH;
  localparam int CNT_W = $clog2(COUNT_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_NUM,
    S_WAIT_NUM,
    S_LOAD_REF,
    S_BROADCAST,
    S_NEXT_PHASE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             phase_q, phase_d;
  logic             rpn_q, rpn_d;
  logic             pause_q, pause_d;
  logic [W-1:0]     ref_id_q, ref_id_d;
  logic [W-1:0]     particle_id_q, particle_id_d;
  logic [W-1:0]     rd_addr_q, rd_addr_d;
  logic             busy_q, busy_d;
  logic             sweep_done_q, sweep_done_d;
  logic [W-1:0]     count_q, count_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             start_accept;
  logic             goto_read;

  assign start_accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    rpn_d         = 1'b0;
    pause_d       = 1'b0;
    ref_id_d      = ref_id_q;
    particle_id_d = particle_id_q;
    rd_addr_d     = rd_addr_q;
    busy_d        = busy_q;
    sweep_done_d  = 1'b0;
    count_d       = count_q;
    wait_cnt_d    = wait_cnt_q;
    goto_read     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          phase_d   = 1'b0;
          goto_read = 1'b1;
        end
      end
      S_READ_NUM: begin
        state_d = S_WAIT_NUM;
      end
      S_WAIT_NUM: begin
        if (wait_cnt_q == CNT_W'(COUNT_LATENCY - 1)) begin
          count_d = ref_particle_count;
          if (ref_particle_count == '0) begin
            state_d = S_NEXT_PHASE;
          end else begin
            state_d       = S_LOAD_REF;
            ref_id_d      = W'(1);
            particle_id_d = '0;
            rd_addr_d     = W'(1);
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_LOAD_REF: begin
        if (back_pressure) begin
          pause_d = 1'b1;
        end else begin
          state_d       = S_BROADCAST;
          particle_id_d = W'(1);
          rd_addr_d     = W'(1);
        end
      end
      S_BROADCAST: begin
        if (back_pressure) begin
          pause_d = 1'b1;
        end else if (particle_id_q == count_q) begin
          // Last ref exits with ref_id = H+1 (may wrap to 0); the exit is decided by the compare.
          ref_id_d = ref_id_q + 1'b1;
          if (ref_id_q == count_q) begin
            state_d = S_NEXT_PHASE;
          end else begin
            state_d       = S_LOAD_REF;
            particle_id_d = '0;
            rd_addr_d     = ref_id_q + 1'b1;
          end
        end else begin
          particle_id_d = particle_id_q + 1'b1;
          rd_addr_d     = particle_id_q + 1'b1;
        end
      end
      S_NEXT_PHASE: begin
        if (!phase_q) begin
          phase_d   = 1'b1;
          goto_read = 1'b1;
        end else begin
          state_d      = S_DONE;
          sweep_done_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        phase_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Count word is re-read at the start of every phase.
    if (goto_read) begin
      state_d       = S_READ_NUM;
      rpn_d         = 1'b1;
      rd_addr_d     = '0;
      ref_id_d      = '0;
      particle_id_d = '0;
      wait_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= 1'b0;
      rpn_q         <= 1'b0;
      pause_q       <= 1'b0;
      ref_id_q      <= '0;
      particle_id_q <= '0;
      rd_addr_q     <= '0;
      busy_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
      count_q       <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      rpn_q         <= rpn_d;
      pause_q       <= pause_d;
      ref_id_q      <= ref_id_d;
      particle_id_q <= particle_id_d;
      rd_addr_q     <= rd_addr_d;
      busy_q        <= busy_d;
      sweep_done_q  <= sweep_done_d;
      count_q       <= count_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign phase                = phase_q;
  assign reading_particle_num = rpn_q;
  assign pause_reading        = pause_q;
  assign ref_id               = ref_id_q;
  assign particle_id          = particle_id_q;
  assign rd_addr              = rd_addr_q;
  assign busy                 = busy_q;
  assign sweep_done           = sweep_done_q;

`ifdef POS_RD_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_WIDTH-1:0] active_cnt_q, active_cnt_d;

  // Counters track the registered busy/pause outputs and stick at all-ones.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    active_cnt_d = active_cnt_q;
    if (start_accept) begin
      stall_cnt_d  = '0;
      active_cnt_d = '0;
    end else begin
      if (busy_q && (active_cnt_q != '1)) active_cnt_d = active_cnt_q + 1'b1;
      if (pause_q && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      active_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      active_cnt_q <= active_cnt_d;
    end
  end

  assign stall_cycles  = stall_cnt_q;
  assign active_cycles = active_cnt_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule
